// File: rtl/dma_copy_engine_pkg.sv
// Shared types and constants for the word-copy DMA engine.
// State encoding is fixed so it can be read back in waveforms by value.
package dma_copy_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } dma_state_e;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dma_addr_gen.sv
// Word pointer register: load a byte address, then step by one word.
// Wraps modulo 2^ADDR_W with no error.
module dma_addr_gen
    import dma_copy_engine_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] ptr_o
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_addr_i;
        end else if (inc_i) begin
            ptr_d = ptr_q + ADDR_W'(WORD_BYTES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/dma_copy_engine.sv
// Single-channel word-copy initiator on the shared data-memory port.
// One granted read then one granted write per word; forward copy only.
module dma_copy_engine
    import dma_copy_engine_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              mem_gnt,
    output logic              mem_req,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Write_data,
    input  logic [DATA_W-1:0] Read_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_done
);

    dma_state_e        state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [LEN_W-1:0]  words_done_q, words_done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              ptr_load;
    logic              src_inc;
    logic              dst_inc;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic              misaligned;

    assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_src_ptr (
        .clk         (clk),
        .reset       (reset),
        .load_i      (ptr_load),
        .load_addr_i (src_addr),
        .inc_i       (src_inc),
        .ptr_o       (src_ptr)
    );

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_dst_ptr (
        .clk         (clk),
        .reset       (reset),
        .load_i      (ptr_load),
        .load_addr_i (dst_addr),
        .inc_i       (dst_inc),
        .ptr_o       (dst_ptr)
    );

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        data_d       = data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        ptr_load     = 1'b0;
        src_inc      = 1'b0;
        dst_inc      = 1'b0;
        mem_req      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Address      = '0;
        Write_data   = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        words_done_d = '0;
                        state_d      = FIN;
                    end else begin
                        ptr_load     = 1'b1;
                        remaining_d  = len;
                        words_done_d = '0;
                        state_d      = READ;
                    end
                end
            end
            READ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    MemRead = 1'b1;
                    Address = src_ptr;
                    data_d  = Read_data;
                    src_inc = 1'b1;
                    state_d = WRITE;
                end
                if (abort) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                mem_req = 1'b1;
                // A granted write lands on this edge even if aborted.
                if (mem_gnt) begin
                    MemWrite     = 1'b1;
                    Address      = dst_ptr;
                    Write_data   = data_q;
                    dst_inc      = 1'b1;
                    words_done_d = words_done_q + LEN_W'(1);
                    remaining_d  = remaining_q - LEN_W'(1);
                    state_d      = (remaining_q == LEN_W'(1)) ? FIN : READ;
                end
                if (abort) begin
                    state_d = IDLE;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            words_done_q <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            data_q       <= data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign busy       = (state_q == READ) || (state_q == WRITE);
    assign done       = done_q;
    assign err        = err_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine with a 256-word behavioural memory.
// Inputs change and outputs are sampled on the falling edge.
module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [8:0]  len;
    logic        abort;
    logic        mem_gnt;
    logic        mem_req;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  words_done;

    logic [31:0] mem [0:255];
    logic [31:0] src_w [0:7];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          op_cnt  = 0;

    always #5 clk = ~clk;

    dma_copy_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .abort      (abort),
        .mem_gnt    (mem_gnt),
        .mem_req    (mem_req),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done)
    );

    assign Read_data = mem[Address[9:2]];

    always @(posedge clk) begin
        if (MemRead || MemWrite) op_cnt <= op_cnt + 1;
        if (MemWrite) mem[Address[9:2]] <= Write_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | i;
        for (int i = 0; i < 8; i++) mem[i] = src_w[i];
    endtask

    task automatic check_copy(input string tag, input int base, input int n);
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_w%0d", tag, base + i), mem[base + i], src_w[i]);
    endtask

    // Start a copy and count falling edges until done; gnt pattern 1,0,0,1 when tog.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                            input logic [8:0] l, input bit tog,
                            output int lat, output int viol);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        mem_gnt  = 1'b1;
        lat      = -1;
        viol     = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if ((MemRead || MemWrite) && !mem_gnt) viol++;
            if (MemRead && MemWrite) viol++;
            if (!(MemRead || MemWrite) && Address != 32'h0) viol++;
            if (done) begin
                lat = k;
                break;
            end
            mem_gnt = tog ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
        end
        mem_gnt = 1'b1;
    endtask

    initial begin
        int lat;
        int viol;
        int ops0;
        bit saw_done;

        src_w[0] = 32'hFFFFFFD3; src_w[1] = 32'h00000003;
        src_w[2] = 32'h00000028; src_w[3] = 32'h00000024;
        src_w[4] = 32'hFFFFFFFE; src_w[5] = 32'h00000006;
        src_w[6] = 32'hFFFFFFF9; src_w[7] = 32'h0000003A;
        init_mem();

        reset = 1'b1; start = 1'b0; abort = 1'b0; mem_gnt = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        #1;
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_memreq", {31'b0, mem_req}, 32'd0);
        check_eq("rst_addr", Address, 32'd0);
        check_eq("rst_wdone", {23'b0, words_done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // full-rate copy of 8 words
        run_copy(32'h0, 32'h40, 9'd8, 1'b0, lat, viol);
        check_eq("full_lat", lat, 32'd18);
        check_eq("full_viol", viol, 32'd0);
        check_eq("full_wdone", {23'b0, words_done}, 32'd8);
        check_copy("full", 16, 8);
        @(negedge clk);
        check_eq("done_1cyc", {31'b0, done}, 32'd0);

        // same copy with grant toggling 1,0,0,1
        init_mem();
        run_copy(32'h0, 32'h40, 9'd8, 1'b1, lat, viol);
        check_eq("tog_lat", lat, 32'd34);
        check_eq("tog_viol", viol, 32'd0);
        check_copy("tog", 16, 8);

        // misaligned source
        init_mem();
        ops0 = op_cnt;
        @(negedge clk);
        src_addr = 32'h2; dst_addr = 32'h40; len = 9'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("mis_err", {31'b0, err}, 32'd1);
        check_eq("mis_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check_eq("mis_err_pulse", {31'b0, err}, 32'd0);
        check_eq("mis_busy2", {31'b0, busy}, 32'd0);
        check_eq("mis_ops", op_cnt - ops0, 32'd0);
        check_eq("mis_mem", mem[16], 32'hDEAD0010);

        // zero-length transfer
        ops0 = op_cnt;
        run_copy(32'h0, 32'h40, 9'd0, 1'b0, lat, viol);
        check_eq("len0_lat", lat, 32'd2);
        check_eq("len0_ops", op_cnt - ops0, 32'd0);

        // abort during the read following the third write
        init_mem();
        saw_done = 1'b0;
        @(negedge clk);
        src_addr = 32'h0; dst_addr = 32'h40; len = 9'd8;
        start = 1'b1; mem_gnt = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) saw_done = 1'b1;
            if (k == 7) abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        check_eq("abt_busy", {31'b0, busy}, 32'd0);
        check_eq("abt_wdone", {23'b0, words_done}, 32'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check_eq("abt_nodone", {31'b0, saw_done}, 32'd0);
        check_eq("abt_wdone_hold", {23'b0, words_done}, 32'd3);
        check_copy("abt", 16, 3);
        check_eq("abt_w19", mem[19], 32'hDEAD0013);
        run_copy(32'h0, 32'h80, 9'd8, 1'b0, lat, viol);
        check_eq("abt_restart_lat", lat, 32'd18);
        check_copy("abt_restart", 32, 8);

        // asynchronous reset while in WRITE
        init_mem();
        @(negedge clk);
        src_addr = 32'h0; dst_addr = 32'h40; len = 9'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_wr", {31'b0, MemWrite}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("arst_busy", {31'b0, busy}, 32'd0);
        check_eq("arst_memreq", {31'b0, mem_req}, 32'd0);
        check_eq("arst_memwr", {31'b0, MemWrite}, 32'd0);
        check_eq("arst_addr", Address, 32'd0);
        check_eq("arst_wdata", Write_data, 32'd0);
        check_eq("arst_wdone", {23'b0, words_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_copy(32'h0, 32'h40, 9'd8, 1'b0, lat, viol);
        check_eq("post_rst_lat", lat, 32'd18);
        check_copy("post_rst", 16, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
